l2_request_arbiter: RTL

Shares the single L1-to-L2 read port between the instruction cache and the data cache. Accepts one refill request at a time from either L1 cache using a valid/ready address handshake, forwards it to L2, then steers the returning beats back to the owning cache. Uses round-robin priority with a single outstanding transaction. Sits between `INSTRUCTION_CACHE`/data cache and the L2 cache.

---
 rtl/l2_request_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/l2_request_arbiter.sv
// Shares the single L1-to-L2 read port between the I-cache and the D-cache.
// One outstanding refill: round-robin grant, forward the address, then pass the L2 beats to the owner.
module l2_request_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int L2_BUS_WIDTH  = 32,
  parameter int BEATS         = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     ADDRESS_TO_L2_VALID_INS,
  output logic                     ADDRESS_TO_L2_READY_INS,
  input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
  output logic                     DATA_FROM_L2_VALID_INS,
  input  logic                     DATA_FROM_L2_READY_INS,
  output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_INS,
  input  logic                     ADDRESS_TO_L2_VALID_DAT,
  output logic                     ADDRESS_TO_L2_READY_DAT,
  input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_DAT,
  output logic                     DATA_FROM_L2_VALID_DAT,
  input  logic                     DATA_FROM_L2_READY_DAT,
  output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_DAT,
  output logic                     ADDRESS_TO_L2_VALID,
  input  logic                     ADDRESS_TO_L2_READY,
  output logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2,
  input  logic                     DATA_FROM_L2_VALID,
  output logic                     DATA_FROM_L2_READY,
  input  logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2,
  output logic                     BUSY,
  output logic                     GRANT_OWNER
);

  localparam int WA    = ADDRESS_WIDTH - 2;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic OWNER_INS = 1'b0;
  localparam logic OWNER_DAT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  state_t            state_r, state_s;
  logic              owner_r, owner_s;
  logic              ptr_r, ptr_s;
  logic [WA-1:0]     addr_r, addr_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;

  logic                    grant_ins_s, grant_dat_s;
  logic                    l2_addr_valid_s;
  logic [WA-1:0]           l2_addr_s;
  logic                    beat_ready_s, beat_done_s;
  logic                    ins_valid_s, dat_valid_s;
  logic [L2_BUS_WIDTH-1:0] ins_data_s, dat_data_s;

  // Next-state logic and the combinational pass-through paths for each phase
  always_comb begin
    state_s         = state_r;
    owner_s         = owner_r;
    ptr_s           = ptr_r;
    addr_s          = addr_r;
    cnt_s           = cnt_r;
    grant_ins_s     = 1'b0;
    grant_dat_s     = 1'b0;
    l2_addr_valid_s = 1'b0;
    l2_addr_s       = {WA{1'b0}};
    beat_ready_s    = 1'b0;
    beat_done_s     = 1'b0;
    ins_valid_s     = 1'b0;
    dat_valid_s     = 1'b0;
    ins_data_s      = {L2_BUS_WIDTH{1'b0}};
    dat_data_s      = {L2_BUS_WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        // A lone requester always wins; on a tie the pointer decides.
        grant_ins_s = ADDRESS_TO_L2_VALID_INS & (~ADDRESS_TO_L2_VALID_DAT | (ptr_r == OWNER_INS));
        grant_dat_s = ADDRESS_TO_L2_VALID_DAT & (~ADDRESS_TO_L2_VALID_INS | (ptr_r == OWNER_DAT));
        if (grant_ins_s) begin
          addr_s  = ADDRESS_TO_L2_INS;
          owner_s = OWNER_INS;
          state_s = ST_ADDR;
        end else if (grant_dat_s) begin
          addr_s  = ADDRESS_TO_L2_DAT;
          owner_s = OWNER_DAT;
          state_s = ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        l2_addr_valid_s = 1'b1;
        l2_addr_s       = addr_r;
        if (ADDRESS_TO_L2_READY) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_DATA;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (owner_r == OWNER_INS) begin
          ins_valid_s  = DATA_FROM_L2_VALID;
          ins_data_s   = DATA_FROM_L2;
          beat_ready_s = DATA_FROM_L2_READY_INS;
        end else begin
          dat_valid_s  = DATA_FROM_L2_VALID;
          dat_data_s   = DATA_FROM_L2;
          beat_ready_s = DATA_FROM_L2_READY_DAT;
        end
        beat_done_s = DATA_FROM_L2_VALID & beat_ready_s;
        if (beat_done_s) begin
          if (cnt_r == LAST_BEAT) begin
            state_s = ST_IDLE;
            ptr_s   = ~owner_r;
          end else begin
            cnt_s = cnt_r + CNT_W'(1'b1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, owner, priority pointer, captured address and beat counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      owner_r <= OWNER_INS;
      ptr_r   <= OWNER_INS;
      addr_r  <= {WA{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      ptr_r   <= ptr_s;
      addr_r  <= addr_s;
      cnt_r   <= cnt_s;
    end
  end

  // Readies are gated by reset so every output reads zero while reset is held.
  assign ADDRESS_TO_L2_READY_INS = grant_ins_s & RST_N;
  assign ADDRESS_TO_L2_READY_DAT = grant_dat_s & RST_N;
  assign ADDRESS_TO_L2_VALID     = l2_addr_valid_s;
  assign ADDRESS_TO_L2           = l2_addr_s;
  assign DATA_FROM_L2_READY      = beat_ready_s;
  assign DATA_FROM_L2_VALID_INS  = ins_valid_s;
  assign DATA_FROM_L2_INS        = ins_data_s;
  assign DATA_FROM_L2_VALID_DAT  = dat_valid_s;
  assign DATA_FROM_L2_DAT        = dat_data_s;
  assign BUSY                    = (state_r != ST_IDLE);
  assign GRANT_OWNER             = owner_r;

endmodule
